// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the core run controller: state encoding, default
// counter width and the saturating-add helper used by sat_counter.
package run_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    RUN      = 3'd2,
    DONE     = 3'd3,
    TIMEOUT  = 3'd4
  } run_state_e;

  // Adds amt to cur and clamps the result at the all-ones value of a
  // width-bit counter. Counters up to 64 bits wide are supported.
  function automatic logic [63:0] sat_add(input logic [63:0]   cur,
                                          input logic [63:0]   amt,
                                          input int unsigned   width);
    logic [64:0] sum;
    logic [63:0] max_val;
    sum     = {1'b0, cur} + {1'b0, amt};
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    if (sum > {1'b0, max_val}) return max_val;
    return sum[63:0];
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Control/status bundle between the run controller (slave) and whoever
// starts runs and observes completion (master). The stall flag exists only
// when RUN_CTRL_STALL_WDOG_EN is defined.
interface core_run_ctrl_if #(
  parameter int NUM_HARTS = 1,
  parameter int CNT_W     = 32
);

  logic                 start;
  logic [NUM_HARTS-1:0] halt_in;
  logic [NUM_HARTS-1:0] retire;
  logic                 core_rst;
  logic                 running;
  logic                 done;
  logic                 timeout;
  logic [NUM_HARTS-1:0] halted_mask;
  logic [CNT_W-1:0]     cycle_count;
  logic [CNT_W-1:0]     instret_count;
`ifdef RUN_CTRL_STALL_WDOG_EN
  logic                 stall;
`endif

  modport master (
`ifdef RUN_CTRL_STALL_WDOG_EN
    input  stall,
`endif
    output start, halt_in, retire,
    input  core_rst, running, done, timeout, halted_mask,
           cycle_count, instret_count
  );

  modport slave (
`ifdef RUN_CTRL_STALL_WDOG_EN
    output stall,
`endif
    input  start, halt_in, retire,
    output core_rst, running, done, timeout, halted_mask,
           cycle_count, instret_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear, enable, and a per-cycle add
// amount. Clear has priority over counting. W must not exceed 64.
module sat_counter
  import run_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] amt,
  output logic [W-1:0] count
);

  // Counter register: clear beats enable; the sum clamps at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= W'(sat_add(64'(count), 64'(amt), W));
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for one or more pipelined cores: holds the cores in reset
// for RST_CYCLES after start, runs them until every hart has halted or the
// cycle budget expires, then freezes them and reports status.
// Optional stall watchdog: define RUN_CTRL_STALL_WDOG_EN.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int NUM_HARTS   = 1,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 18,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int STALL_LIMIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  core_run_ctrl_if.slave bus
);

  // Reject configurations the hold counter or stall watchdog cannot express.
  if (RST_CYCLES < 1 || RST_CYCLES > 255 || STALL_LIMIT < 1) begin : g_bad_cfg
    $error("core_run_ctrl: RST_CYCLES must be 1..255 and STALL_LIMIT >= 1");
  end

  // Value cycle_count holds during the final budgeted RUN cycle.
  localparam logic [CNT_W-1:0] LAST_RUN =
    (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

  run_state_e           state_q, state_d;
  logic [7:0]           hold_q;
  logic [NUM_HARTS-1:0] halted_q;
  logic [CNT_W-1:0]     cycle_count;
  logic [CNT_W-1:0]     instret_count;
  logic                 in_run;
  logic                 start_ok;
  logic                 run_entry;
  logic                 all_halted;
  logic                 budget_hit;
  logic                 stall_hit;

  assign in_run     = (state_q == RUN);
  assign start_ok   = bus.start && (state_q inside {IDLE, DONE, TIMEOUT});
  assign run_entry  = (state_q == RST_HOLD) && (hold_q == 8'd1);
  // Includes this cycle's halt bits so the final halt exits on its own edge.
  assign all_halted = &(halted_q | bus.halt_in);
  assign budget_hit = (MAX_CYCLES != 0) && (cycle_count == LAST_RUN);

  // Next-state selection; halt completion outranks any timeout cause.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, TIMEOUT: if (start_ok) state_d = RST_HOLD;
      RST_HOLD:            if (run_entry) state_d = RUN;
      RUN: begin
        if (all_halted)                  state_d = DONE;
        else if (stall_hit || budget_hit) state_d = TIMEOUT;
      end
      default:             state_d = IDLE;
    endcase
  end

  // State register; block reset wins over every other event.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Reset-hold countdown, loaded when a run is accepted.
  always_ff @(posedge clk) begin
    if (!reset)                   hold_q <= '0;
    else if (start_ok)            hold_q <= 8'(RST_CYCLES);
    else if (state_q == RST_HOLD) hold_q <= hold_q - 8'd1;
  end

  // Sticky per-hart halt record, cleared when a new run is accepted.
  always_ff @(posedge clk) begin
    if (!reset)        halted_q <= '0;
    else if (start_ok) halted_q <= '0;
    else if (in_run)   halted_q <= halted_q | bus.halt_in;
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (in_run),
    .amt   (CNT_W'(1)),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (in_run),
    .amt   (CNT_W'($countones(bus.retire))),
    .count (instret_count)
  );

`ifdef RUN_CTRL_STALL_WDOG_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               any_retire;
  logic               stall_q;

  assign any_retire = |bus.retire;
  // Fires on the cycle whose increment would reach STALL_LIMIT.
  assign stall_hit  = in_run && !any_retire &&
                      (stall_cnt == STALL_W'(STALL_LIMIT - 1));

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (run_entry || (in_run && any_retire)),
    .en    (in_run),
    .amt   (STALL_W'(1)),
    .count (stall_cnt)
  );

  // Sticky stall flag; only set when the stall causes the timeout.
  always_ff @(posedge clk) begin
    if (!reset)                                stall_q <= 1'b0;
    else if (start_ok)                         stall_q <= 1'b0;
    else if (in_run && stall_hit && !all_halted) stall_q <= 1'b1;
  end

  assign bus.stall = stall_q;
`else
  assign stall_hit = 1'b0;
`endif

  // Status outputs decode the state register directly, so none of them
  // has a combinational path from an input.
  assign bus.core_rst      = !in_run;
  assign bus.running       = in_run;
  assign bus.done          = (state_q == DONE);
  assign bus.timeout       = (state_q == TIMEOUT);
  assign bus.halted_mask   = halted_q;
  assign bus.cycle_count   = cycle_count;
  assign bus.instret_count = instret_count;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed testbench for core_run_ctrl with two harts, RST_CYCLES=2 and
// MAX_CYCLES=18. The stall scenario is included when RUN_CTRL_STALL_WDOG_EN
// is defined.
module tb_core_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  core_run_ctrl_if #(.NUM_HARTS(2), .CNT_W(32)) bus ();

  core_run_ctrl #(
    .NUM_HARTS   (2),
    .RST_CYCLES  (2),
    .MAX_CYCLES  (18),
    .CNT_W       (32),
    .STALL_LIMIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL %s core_rst: got %0d expected 1", tag, bus.core_rst); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL %s running: got %0d expected 0", tag, bus.running); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done: got %0d expected 0", tag, bus.done); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL %s timeout: got %0d expected 0", tag, bus.timeout); end
    checks++; if (bus.halted_mask !== 2'b00) begin errors++; $display("FAIL %s halted_mask: got %b expected 00", tag, bus.halted_mask); end
    checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL %s cycle_count: got %0d expected 0", tag, bus.cycle_count); end
    checks++; if (bus.instret_count !== 32'd0) begin errors++; $display("FAIL %s instret_count: got %0d expected 0", tag, bus.instret_count); end
  endtask

  // Pulse start from IDLE/DONE/TIMEOUT and wait for RUN cycle 1.
  task automatic start_run(input string tag);
    int hold;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.core_rst !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL %s hold_entry: got core_rst=%0d running=%0d expected 1/0", tag, bus.core_rst, bus.running); end
    checks++; if (bus.done !== 1'b0 || bus.timeout !== 1'b0) begin errors++; $display("FAIL %s start_clears_status: got done=%0d timeout=%0d expected 0/0", tag, bus.done, bus.timeout); end
    checks++; if (bus.cycle_count !== 32'd0 || bus.instret_count !== 32'd0 || bus.halted_mask !== 2'b00) begin errors++; $display("FAIL %s start_clears_counts: got cyc=%0d ret=%0d mask=%b expected 0/0/00", tag, bus.cycle_count, bus.instret_count, bus.halted_mask); end
`ifdef RUN_CTRL_STALL_WDOG_EN
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL %s start_clears_stall: got %0d expected 0", tag, bus.stall); end
`endif
    hold = 0;
    while (!bus.running && hold < 20) begin
      tick();
      hold++;
    end
    checks++; if (hold !== 2) begin errors++; $display("FAIL %s hold_len: got %0d expected 2", tag, hold); end
    checks++; if (bus.core_rst !== 1'b0) begin errors++; $display("FAIL %s run_core_rst: got %0d expected 0", tag, bus.core_rst); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();
    checks++; if (bus.core_rst !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got core_rst=%0d running=%0d expected 1/0", bus.core_rst, bus.running); end
  endtask

  task automatic test_budget();
    int n;
    start_run("budget");
    bus.retire = 2'b01;
    n = 0;
    while (bus.running && n < 100) begin
      tick();
      n++;
    end
    bus.retire = 2'b00;
    checks++; if (n !== 18) begin errors++; $display("FAIL budget_run_len: got %0d expected 18", n); end
    checks++; if (bus.timeout !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL budget_status: got timeout=%0d done=%0d expected 1/0", bus.timeout, bus.done); end
    checks++; if (bus.cycle_count !== 32'd18) begin errors++; $display("FAIL budget_cycle_count: got %0d expected 18", bus.cycle_count); end
    checks++; if (bus.instret_count !== 32'd18) begin errors++; $display("FAIL budget_instret: got %0d expected 18", bus.instret_count); end
    checks++; if (bus.core_rst !== 1'b1) begin errors++; $display("FAIL budget_core_rst: got %0d expected 1", bus.core_rst); end
    tick();
    tick();
    checks++; if (bus.timeout !== 1'b1 || bus.cycle_count !== 32'd18) begin errors++; $display("FAIL timeout_sticky: got timeout=%0d cyc=%0d expected 1/18", bus.timeout, bus.cycle_count); end
  endtask

  task automatic test_halt();
    start_run("halt");
    tick();
    tick();
    bus.halt_in = 2'b01;
    tick();
    bus.halt_in = 2'b00;
    checks++; if (bus.halted_mask !== 2'b01) begin errors++; $display("FAIL halt_mask_first: got %b expected 01", bus.halted_mask); end
    checks++; if (bus.running !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL halt_partial_running: got running=%0d done=%0d expected 1/0", bus.running, bus.done); end
    repeat (3) tick();
    bus.halt_in = 2'b10;
    tick();
    bus.halt_in = 2'b00;
    checks++; if (bus.halted_mask !== 2'b11) begin errors++; $display("FAIL halt_mask_all: got %b expected 11", bus.halted_mask); end
    checks++; if (bus.done !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL halt_status: got done=%0d timeout=%0d expected 1/0", bus.done, bus.timeout); end
    checks++; if (bus.cycle_count !== 32'd7) begin errors++; $display("FAIL halt_cycle_count: got %0d expected 7", bus.cycle_count); end
    checks++; if (bus.core_rst !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL halt_frozen: got core_rst=%0d running=%0d expected 1/0", bus.core_rst, bus.running); end
  endtask

  task automatic test_retire();
    start_run("retire");
    bus.retire = 2'b11;
    repeat (5) tick();
    bus.retire = 2'b01;
    repeat (3) tick();
    bus.retire = 2'b00;
    checks++; if (bus.instret_count !== 32'd13) begin errors++; $display("FAIL retire_sum: got %0d expected 13", bus.instret_count); end
    checks++; if (bus.cycle_count !== 32'd8 || bus.running !== 1'b1) begin errors++; $display("FAIL retire_running: got cyc=%0d running=%0d expected 8/1", bus.cycle_count, bus.running); end
    bus.halt_in = 2'b11;
    tick();
    bus.halt_in = 2'b00;
    checks++; if (bus.done !== 1'b1 || bus.cycle_count !== 32'd9) begin errors++; $display("FAIL retire_both_halt: got done=%0d cyc=%0d expected 1/9", bus.done, bus.cycle_count); end
    tick();
    checks++; if (bus.instret_count !== 32'd13) begin errors++; $display("FAIL retire_hold_in_done: got %0d expected 13", bus.instret_count); end
  endtask

  task automatic test_coincide();
    start_run("coincide");
    bus.retire = 2'b01;
    repeat (17) tick();
    checks++; if (bus.cycle_count !== 32'd17 || bus.running !== 1'b1) begin errors++; $display("FAIL coincide_pre: got cyc=%0d running=%0d expected 17/1", bus.cycle_count, bus.running); end
    bus.halt_in = 2'b11;
    tick();
    bus.halt_in = 2'b00;
    bus.retire  = 2'b00;
    checks++; if (bus.done !== 1'b1 || bus.timeout !== 1'b0) begin errors++; $display("FAIL coincide_status: got done=%0d timeout=%0d expected 1/0", bus.done, bus.timeout); end
    checks++; if (bus.cycle_count !== 32'd18) begin errors++; $display("FAIL coincide_cycle_count: got %0d expected 18", bus.cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    start_run("reset_mid");
    bus.retire = 2'b01;
    repeat (4) tick();
    checks++; if (bus.cycle_count !== 32'd4) begin errors++; $display("FAIL reset_mid_pre: got %0d expected 4", bus.cycle_count); end
    reset       = 1'b0;
    bus.halt_in = 2'b11;
    tick();
    reset       = 1'b1;
    bus.halt_in = 2'b00;
    bus.retire  = 2'b00;
    check_reset_values("reset_mid");
    tick();
    checks++; if (bus.core_rst !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: got core_rst=%0d running=%0d expected 1/0", bus.core_rst, bus.running); end
  endtask

  task automatic test_start_ignored();
    start_run("start_ign");
    bus.retire = 2'b01;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.cycle_count !== 32'd4 || bus.running !== 1'b1 || bus.core_rst !== 1'b0) begin errors++; $display("FAIL start_ignored: got cyc=%0d running=%0d core_rst=%0d expected 4/1/0", bus.cycle_count, bus.running, bus.core_rst); end
    repeat (2) tick();
    checks++; if (bus.cycle_count !== 32'd6) begin errors++; $display("FAIL start_ignored_continue: got %0d expected 6", bus.cycle_count); end
    bus.halt_in = 2'b11;
    tick();
    bus.halt_in = 2'b00;
    bus.retire  = 2'b00;
    checks++; if (bus.done !== 1'b1 || bus.cycle_count !== 32'd7) begin errors++; $display("FAIL start_ignored_end: got done=%0d cyc=%0d expected 1/7", bus.done, bus.cycle_count); end
  endtask

`ifdef RUN_CTRL_STALL_WDOG_EN
  task automatic test_stall();
    int n;
    start_run("stall");
    n = 0;
    while (bus.running && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL stall_run_len: got %0d expected 8", n); end
    checks++; if (bus.stall !== 1'b1 || bus.timeout !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL stall_status: got stall=%0d timeout=%0d done=%0d expected 1/1/0", bus.stall, bus.timeout, bus.done); end
    checks++; if (bus.cycle_count !== 32'd8) begin errors++; $display("FAIL stall_cycle_count: got %0d expected 8", bus.cycle_count); end
    start_run("stall_restart");
    repeat (5) tick();
    bus.retire = 2'b01;
    tick();
    bus.retire = 2'b00;
    n = 0;
    while (bus.running && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n !== 8 || bus.cycle_count !== 32'd14) begin errors++; $display("FAIL stall_window_restart: got n=%0d cyc=%0d expected 8/14", n, bus.cycle_count); end
    checks++; if (bus.stall !== 1'b1 || bus.timeout !== 1'b1) begin errors++; $display("FAIL stall_restart_status: got stall=%0d timeout=%0d expected 1/1", bus.stall, bus.timeout); end
  endtask
`endif

  // Hard stop in case the design never lets the sequence finish.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.halt_in = 2'b00;
    bus.retire  = 2'b00;
    test_reset();
    test_budget();
    test_halt();
    test_retire();
    test_coincide();
    test_reset_mid_run();
    test_start_ignored();
`ifdef RUN_CTRL_STALL_WDOG_EN
    test_stall();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
